scalar_scoreboard: RTL and testbench

//  Scalar scoreboard between dispatch and issue. Holds one FU status row per scalar FU
//  (ALU=0, LD_ST=1, BRANCH=2), each with busy, r, r1, r2, t1, t2, issued.

---
 rtl/scalar_scoreboard.sv | 147 ++++++++++++++
 tb/tb_scalar_scoreboard.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scalar_scoreboard.sv
// Scalar scoreboard between dispatch and issue: per-FU status rows plus a
// register-result-status table, producing dispatch hazard, issue readiness and WAR-gated writeback.
module scalar_scoreboard #(
   parameter int unsigned NUM_FU  = 3,
   parameter int unsigned NUM_REG = 32,
   parameter int unsigned TAG_W   = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              disp_valid,
   input  logic [TAG_W-1:0]  disp_fu,
   input  logic [4:0]        disp_rd,
   input  logic              disp_rd_we,
   input  logic [4:0]        disp_rs1,
   input  logic [4:0]        disp_rs2,
   output logic              hazard,
   output logic [NUM_FU-1:0] issue_ready,
   input  logic [NUM_FU-1:0] issue_grant,
   input  logic              wb_valid,
   input  logic [TAG_W-1:0]  wb_fu,
   output logic              wb_ready,
   output logic [NUM_FU-1:0] fu_busy
);

   localparam int unsigned REG_W = 5;
   localparam logic [TAG_W-1:0] TAG_NONE = '1;

   typedef struct packed {
      logic             busy;
      logic             issued;
      logic [REG_W-1:0] r;
      logic [REG_W-1:0] r1;
      logic [REG_W-1:0] r2;
      logic [TAG_W-1:0] t1;
      logic [TAG_W-1:0] t2;
   } row_t;

   row_t               row_q [NUM_FU];
   row_t               row_d [NUM_FU];
   logic [NUM_REG-1:0] rrs_valid_q, rrs_valid_d;
   logic [TAG_W-1:0]   rrs_fu_q [NUM_REG];
   logic [TAG_W-1:0]   rrs_fu_d [NUM_REG];

   logic               disp_busy, disp_acc, war, wb_busy, wb_acc;
   logic [REG_W-1:0]   wb_r;
   logic [TAG_W-1:0]   t1_new, t2_new;

   // Hazard, readiness and writeback decode from registered state.
   always_comb begin
      disp_busy = 1'b1;
      wb_r      = '0;
      wb_busy   = 1'b0;
      war       = 1'b0;
      for (int unsigned f = 0; f < NUM_FU; f++) begin
         if (disp_fu == TAG_W'(f)) disp_busy = row_q[f].busy;
         if (wb_fu == TAG_W'(f)) begin
            wb_r    = row_q[f].r;
            wb_busy = row_q[f].busy;
         end
      end
      for (int unsigned g = 0; g < NUM_FU; g++) begin
         if (wb_fu != TAG_W'(g) && row_q[g].busy && !row_q[g].issued &&
             ((row_q[g].r1 == wb_r && row_q[g].t1 == TAG_NONE) ||
              (row_q[g].r2 == wb_r && row_q[g].t2 == TAG_NONE)))
            war = 1'b1;
      end
      hazard   = disp_valid & (disp_busy |
                 (disp_rd_we & (disp_rd != '0) & rrs_valid_q[disp_rd]));
      disp_acc = disp_valid & ~hazard;
      wb_ready = ~(wb_valid & (wb_r != '0) & war);
      wb_acc   = wb_valid & wb_ready & wb_busy;

      t1_new = (disp_rs1 == '0 || !rrs_valid_q[disp_rs1]) ? TAG_NONE : rrs_fu_q[disp_rs1];
      t2_new = (disp_rs2 == '0 || !rrs_valid_q[disp_rs2]) ? TAG_NONE : rrs_fu_q[disp_rs2];
      // Producer completing this very cycle: operand is already available.
      if (wb_acc && t1_new == wb_fu) t1_new = TAG_NONE;
      if (wb_acc && t2_new == wb_fu) t2_new = TAG_NONE;

      for (int unsigned f = 0; f < NUM_FU; f++) begin
         issue_ready[f] = row_q[f].busy & ~row_q[f].issued &
                          (row_q[f].t1 == TAG_NONE) & (row_q[f].t2 == TAG_NONE);
         fu_busy[f]     = row_q[f].busy;
      end
   end

   // Next-state: issue, then writeback release, then dispatch allocation.
   always_comb begin
      row_d       = row_q;
      rrs_valid_d = rrs_valid_q;
      rrs_fu_d    = rrs_fu_q;
      for (int unsigned f = 0; f < NUM_FU; f++) begin
         if (issue_grant[f] && issue_ready[f]) row_d[f].issued = 1'b1;
      end
      if (wb_acc) begin
         for (int unsigned f = 0; f < NUM_FU; f++) begin
            if (wb_fu == TAG_W'(f)) begin
               row_d[f].busy   = 1'b0;
               row_d[f].issued = 1'b0;
               row_d[f].t1     = TAG_NONE;
               row_d[f].t2     = TAG_NONE;
            end else begin
               if (row_q[f].t1 == wb_fu) row_d[f].t1 = TAG_NONE;
               if (row_q[f].t2 == wb_fu) row_d[f].t2 = TAG_NONE;
            end
         end
         if (rrs_fu_q[wb_r] == wb_fu) rrs_valid_d[wb_r] = 1'b0;
      end
      if (disp_acc) begin
         for (int unsigned f = 0; f < NUM_FU; f++) begin
            if (disp_fu == TAG_W'(f)) begin
               row_d[f].busy   = 1'b1;
               row_d[f].issued = 1'b0;
               row_d[f].r      = disp_rd_we ? disp_rd : '0;
               row_d[f].r1     = disp_rs1;
               row_d[f].r2     = disp_rs2;
               row_d[f].t1     = t1_new;
               row_d[f].t2     = t2_new;
            end
         end
         if (disp_rd_we && disp_rd != '0) begin
            rrs_valid_d[disp_rd] = 1'b1;
            rrs_fu_d[disp_rd]    = disp_fu;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int unsigned f = 0; f < NUM_FU; f++) begin
            row_q[f].busy   <= 1'b0;
            row_q[f].issued <= 1'b0;
            row_q[f].r      <= '0;
            row_q[f].r1     <= '0;
            row_q[f].r2     <= '0;
            row_q[f].t1     <= TAG_NONE;
            row_q[f].t2     <= TAG_NONE;
         end
         rrs_valid_q <= '0;
         for (int unsigned i = 0; i < NUM_REG; i++) rrs_fu_q[i] <= TAG_NONE;
      end else begin
         row_q       <= row_d;
         rrs_valid_q <= rrs_valid_d;
         rrs_fu_q    <= rrs_fu_d;
      end
   end

endmodule

// File: tb/tb_scalar_scoreboard.sv
// Directed bench for scalar_scoreboard: reset, RAW, structural/WAW, WAR,
// same-cycle bypass, x0 handling and mid-operation reset.
module tb_scalar_scoreboard;

   logic       CLK = 1'b0;
   logic       RST;
   logic       disp_valid;
   logic [1:0] disp_fu;
   logic [4:0] disp_rd;
   logic       disp_rd_we;
   logic [4:0] disp_rs1;
   logic [4:0] disp_rs2;
   logic       hazard;
   logic [2:0] issue_ready;
   logic [2:0] issue_grant;
   logic       wb_valid;
   logic [1:0] wb_fu;
   logic       wb_ready;
   logic [2:0] fu_busy;

   int pass_cnt  = 0;
   int total_cnt = 0;

   scalar_scoreboard dut (
      .CLK(CLK), .RST(RST),
      .disp_valid(disp_valid), .disp_fu(disp_fu), .disp_rd(disp_rd),
      .disp_rd_we(disp_rd_we), .disp_rs1(disp_rs1), .disp_rs2(disp_rs2),
      .hazard(hazard), .issue_ready(issue_ready), .issue_grant(issue_grant),
      .wb_valid(wb_valid), .wb_fu(wb_fu), .wb_ready(wb_ready), .fu_busy(fu_busy)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      disp_valid  = 1'b0;
      disp_fu     = 2'd0;
      disp_rd     = 5'd0;
      disp_rd_we  = 1'b0;
      disp_rs1    = 5'd0;
      disp_rs2    = 5'd0;
      issue_grant = 3'b000;
      wb_valid    = 1'b0;
      wb_fu       = 2'd0;
   endtask

   task automatic drive_disp(input logic [1:0] fu, input logic [4:0] rd, input logic we,
                             input logic [4:0] a, input logic [4:0] b);
      disp_valid = 1'b1;
      disp_fu    = fu;
      disp_rd    = rd;
      disp_rd_we = we;
      disp_rs1   = a;
      disp_rs2   = b;
      #1;
   endtask

   task automatic reset_dut();
      idle();
      RST = 1'b1;
      step();
      step();
      RST = 1'b0;
   endtask

   task automatic test_reset();
      reset_dut();
      total_cnt++; if (fu_busy !== 3'b000) $display("FAIL rst_busy: got %b want 000", fu_busy); else pass_cnt++;
      total_cnt++; if (hazard !== 1'b0) $display("FAIL rst_hazard: got %b want 0", hazard); else pass_cnt++;
      total_cnt++; if (issue_ready !== 3'b000) $display("FAIL rst_ready: got %b want 000", issue_ready); else pass_cnt++;
      total_cnt++; if (wb_ready !== 1'b1) $display("FAIL rst_wb_ready: got %b want 1", wb_ready); else pass_cnt++;
   endtask

   task automatic test_raw();
      reset_dut();
      drive_disp(2'd0, 5'd5, 1'b1, 5'd1, 5'd2);
      total_cnt++; if (hazard !== 1'b0) $display("FAIL raw_disp_alu: got %b want 0", hazard); else pass_cnt++;
      step();
      drive_disp(2'd2, 5'd0, 1'b0, 5'd5, 5'd3);
      total_cnt++; if (issue_ready !== 3'b001) $display("FAIL raw_alu_ready: got %b want 001", issue_ready); else pass_cnt++;
      step();
      idle();
      #1;
      total_cnt++; if (issue_ready !== 3'b001) $display("FAIL raw_br_wait: got %b want 001", issue_ready); else pass_cnt++;
      total_cnt++; if (fu_busy !== 3'b101) $display("FAIL raw_busy: got %b want 101", fu_busy); else pass_cnt++;
      issue_grant = 3'b001;
      step();
      issue_grant = 3'b000;
      wb_valid = 1'b1; wb_fu = 2'd0;
      #1;
      total_cnt++; if (wb_ready !== 1'b1) $display("FAIL raw_wb_ready: got %b want 1", wb_ready); else pass_cnt++;
      step();
      idle();
      #1;
      total_cnt++; if (issue_ready !== 3'b100) $display("FAIL raw_br_ready: got %b want 100", issue_ready); else pass_cnt++;
      total_cnt++; if (fu_busy !== 3'b100) $display("FAIL raw_busy_after_wb: got %b want 100", fu_busy); else pass_cnt++;
      drive_disp(2'd1, 5'd5, 1'b1, 5'd0, 5'd0);
      total_cnt++; if (hazard !== 1'b0) $display("FAIL raw_rrs_cleared: got %b want 0", hazard); else pass_cnt++;
      idle();
   endtask

   task automatic test_struct_waw();
      reset_dut();
      drive_disp(2'd0, 5'd7, 1'b1, 5'd1, 5'd2);
      step();
      drive_disp(2'd0, 5'd10, 1'b1, 5'd1, 5'd2);
      total_cnt++; if (hazard !== 1'b1) $display("FAIL struct_alu_busy: got %b want 1", hazard); else pass_cnt++;
      drive_disp(2'd1, 5'd7, 1'b1, 5'd3, 5'd0);
      total_cnt++; if (hazard !== 1'b1) $display("FAIL waw_x7: got %b want 1", hazard); else pass_cnt++;
      drive_disp(2'd3, 5'd11, 1'b1, 5'd0, 5'd0);
      total_cnt++; if (hazard !== 1'b1) $display("FAIL illegal_fu: got %b want 1", hazard); else pass_cnt++;
      disp_valid = 1'b0; disp_fu = 2'd0;
      #1;
      total_cnt++; if (hazard !== 1'b0) $display("FAIL hazard_no_valid: got %b want 0", hazard); else pass_cnt++;
      drive_disp(2'd1, 5'd8, 1'b1, 5'd3, 5'd0);
      total_cnt++; if (hazard !== 1'b0) $display("FAIL ldst_x8: got %b want 0", hazard); else pass_cnt++;
      step();
      idle();
      #1;
      total_cnt++; if (fu_busy !== 3'b011) $display("FAIL struct_busy: got %b want 011", fu_busy); else pass_cnt++;
   endtask

   task automatic test_war();
      reset_dut();
      drive_disp(2'd1, 5'd12, 1'b1, 5'd9, 5'd0);
      step();
      drive_disp(2'd0, 5'd9, 1'b1, 5'd1, 5'd2);
      total_cnt++; if (hazard !== 1'b0) $display("FAIL war_disp_alu: got %b want 0", hazard); else pass_cnt++;
      step();
      idle();
      #1;
      total_cnt++; if (issue_ready !== 3'b011) $display("FAIL war_ready: got %b want 011", issue_ready); else pass_cnt++;
      issue_grant = 3'b001;
      step();
      issue_grant = 3'b000;
      wb_valid = 1'b1; wb_fu = 2'd0;
      #1;
      total_cnt++; if (wb_ready !== 1'b0) $display("FAIL war_block: got %b want 0", wb_ready); else pass_cnt++;
      step();
      total_cnt++; if (fu_busy !== 3'b011) $display("FAIL war_held: got %b want 011", fu_busy); else pass_cnt++;
      issue_grant = 3'b010;
      step();
      issue_grant = 3'b000;
      #1;
      total_cnt++; if (wb_ready !== 1'b1) $display("FAIL war_release: got %b want 1", wb_ready); else pass_cnt++;
      step();
      idle();
      #1;
      total_cnt++; if (fu_busy !== 3'b010) $display("FAIL war_accepted: got %b want 010", fu_busy); else pass_cnt++;
      drive_disp(2'd2, 5'd9, 1'b1, 5'd0, 5'd0);
      total_cnt++; if (hazard !== 1'b0) $display("FAIL war_rrs_cleared: got %b want 0", hazard); else pass_cnt++;
      idle();
   endtask

   task automatic test_same_cycle();
      reset_dut();
      drive_disp(2'd0, 5'd4, 1'b1, 5'd1, 5'd2);
      step();
      idle();
      issue_grant = 3'b001;
      step();
      issue_grant = 3'b000;
      wb_valid = 1'b1; wb_fu = 2'd0;
      drive_disp(2'd2, 5'd0, 1'b0, 5'd4, 5'd4);
      total_cnt++; if (hazard !== 1'b0) $display("FAIL byp_hazard: got %b want 0", hazard); else pass_cnt++;
      total_cnt++; if (wb_ready !== 1'b1) $display("FAIL byp_wb_ready: got %b want 1", wb_ready); else pass_cnt++;
      step();
      idle();
      #1;
      total_cnt++; if (issue_ready !== 3'b100) $display("FAIL byp_ready: got %b want 100", issue_ready); else pass_cnt++;
      total_cnt++; if (fu_busy !== 3'b100) $display("FAIL byp_busy: got %b want 100", fu_busy); else pass_cnt++;
   endtask

   task automatic test_same_fu_wb_dispatch();
      reset_dut();
      drive_disp(2'd0, 5'd6, 1'b1, 5'd1, 5'd2);
      step();
      idle();
      issue_grant = 3'b001;
      step();
      issue_grant = 3'b000;
      wb_valid = 1'b1; wb_fu = 2'd0;
      drive_disp(2'd0, 5'd13, 1'b1, 5'd6, 5'd0);
      total_cnt++; if (hazard !== 1'b1) $display("FAIL samefu_stall: got %b want 1", hazard); else pass_cnt++;
      step();
      wb_valid = 1'b0;
      #1;
      total_cnt++; if (fu_busy !== 3'b000) $display("FAIL samefu_freed: got %b want 000", fu_busy); else pass_cnt++;
      total_cnt++; if (hazard !== 1'b0) $display("FAIL samefu_enter: got %b want 0", hazard); else pass_cnt++;
      step();
      idle();
      wb_valid = 1'b1; wb_fu = 2'd2;
      #1;
      total_cnt++; if (issue_ready !== 3'b001) $display("FAIL samefu_ready: got %b want 001", issue_ready); else pass_cnt++;
      step();
      idle();
      #1;
      total_cnt++; if (fu_busy !== 3'b001) $display("FAIL wb_idle_fu: got %b want 001", fu_busy); else pass_cnt++;
   endtask

   task automatic test_x0_and_reset();
      reset_dut();
      drive_disp(2'd0, 5'd0, 1'b1, 5'd0, 5'd0);
      step();
      drive_disp(2'd1, 5'd0, 1'b1, 5'd0, 5'd0);
      total_cnt++; if (hazard !== 1'b0) $display("FAIL x0_no_waw: got %b want 0", hazard); else pass_cnt++;
      step();
      drive_disp(2'd2, 5'd0, 1'b1, 5'd0, 5'd0);
      step();
      idle();
      #1;
      total_cnt++; if (fu_busy !== 3'b111) $display("FAIL x0_busy: got %b want 111", fu_busy); else pass_cnt++;
      total_cnt++; if (issue_ready !== 3'b111) $display("FAIL x0_ready: got %b want 111", issue_ready); else pass_cnt++;
      wb_valid = 1'b1; wb_fu = 2'd0;
      #1;
      total_cnt++; if (wb_ready !== 1'b1) $display("FAIL x0_no_war: got %b want 1", wb_ready); else pass_cnt++;
      wb_valid = 1'b0;
      RST = 1'b1;
      step();
      RST = 1'b0;
      #1;
      total_cnt++; if (fu_busy !== 3'b000) $display("FAIL midrst_busy: got %b want 000", fu_busy); else pass_cnt++;
      total_cnt++; if (issue_ready !== 3'b000) $display("FAIL midrst_ready: got %b want 000", issue_ready); else pass_cnt++;
      drive_disp(2'd2, 5'd0, 1'b0, 5'd0, 5'd0);
      total_cnt++; if (hazard !== 1'b0) $display("FAIL midrst_hazard: got %b want 0", hazard); else pass_cnt++;
      idle();
   endtask

   initial begin
      RST = 1'b1;
      idle();
      test_reset();
      test_raw();
      test_struct_waw();
      test_war();
      test_same_cycle();
      test_same_fu_wb_dispatch();
      test_x0_and_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
